// File: rtl/pipe_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: default sizes, shift-op encodings
// and the helper that spreads mux levels across pipeline stages.
package pipe_shifter_pkg;

  localparam int DATA_WIDTH_DEF  = 32;
  localparam int TAG_W_DEF       = 5;
  localparam int PIPE_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    SHOP_SLL = 2'b00,
    SHOP_ROR = 2'b01,
    SHOP_SRL = 2'b10,
    SHOP_SRA = 2'b11
  } shop_e;

  function automatic int levels_per_stage(input int shamt_w, input int stages);
    return (shamt_w + stages - 1) / stages;
  endfunction

endpackage

// File: rtl/pipe_shifter_stage.sv
// One pipeline stage: NUM_LVL combinational shift levels starting at FIRST_LVL, followed by
// the stage register (valid, data and the sideband that later stages still need).
module shifter_stage
  import pipe_shifter_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH),
  parameter int TAG_W      = TAG_W_DEF,
  parameter int FIRST_LVL  = 0,
  parameter int NUM_LVL    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [SHAMT_W-1:0]    in_b,
  input  logic [1:0]            in_op,
  input  logic                  in_sign,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [SHAMT_W-1:0]    out_b,
  output logic [1:0]            out_op,
  output logic                  out_sign,
  output logic [TAG_W-1:0]      out_tag
);

  logic [DATA_WIDTH-1:0] lvl [NUM_LVL+1];

  assign lvl[0] = in_data;

  for (genvar gi = 0; gi < NUM_LVL; gi++) begin : g_lvl
    localparam int K = FIRST_LVL + gi;
    localparam int S = 1 << K;
    // Sign fill uses the sign of the original operand, not of the partially shifted value.
    localparam logic [DATA_WIDTH-1:0] FILL = ~({DATA_WIDTH{1'b1}} >> S);
    logic [DATA_WIDTH-1:0] shifted;

    always_comb begin
      case (in_op)
        SHOP_SLL: shifted = lvl[gi] << S;
        SHOP_ROR: shifted = (lvl[gi] >> S) | (lvl[gi] << (DATA_WIDTH - S));
        SHOP_SRL: shifted = lvl[gi] >> S;
        default:  shifted = (lvl[gi] >> S) | (in_sign ? FILL : '0);
      endcase
    end

    assign lvl[gi+1] = in_b[K] ? shifted : lvl[gi];
  end

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  logic [SHAMT_W-1:0]    b_q,     b_d;
  logic [1:0]            op_q,    op_d;
  logic                  sign_q,  sign_d;
  logic [TAG_W-1:0]      tag_q,   tag_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    b_d     = b_q;
    op_d    = op_q;
    sign_d  = sign_q;
    tag_d   = tag_q;
    if (load) begin
      valid_d = in_valid;
      if (in_valid) begin
        data_d = lvl[NUM_LVL];
        b_d    = in_b;
        op_d   = in_op;
        sign_d = in_sign;
        tag_d  = in_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      b_q     <= '0;
      op_q    <= '0;
      sign_q  <= 1'b0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      b_q     <= b_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
      tag_q   <= tag_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_b     = b_q;
  assign out_op    = op_q;
  assign out_sign  = sign_q;
  assign out_tag   = tag_q;

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter (SLL/ROR/SRL/SRA) with valid/ready on both sides and a tag that
// travels with each operation. Stage enables ripple back from out_ready so bubbles collapse.
module pipe_shifter
  import pipe_shifter_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int SHAMT_W     = $clog2(DATA_WIDTH),
  parameter int PIPE_STAGES = PIPE_STAGES_DEF,
  parameter int TAG_W       = TAG_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [SHAMT_W-1:0]    B,
  input  logic [1:0]            Shiftop,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result,
  output logic [TAG_W-1:0]      out_tag
);

  localparam int LPS = levels_per_stage(SHAMT_W, PIPE_STAGES);

  // Index 0 is the request port; index i+1 is the register output of stage i.
  logic                  st_valid [PIPE_STAGES+1];
  logic [DATA_WIDTH-1:0] st_data  [PIPE_STAGES+1];
  logic [SHAMT_W-1:0]    st_b     [PIPE_STAGES+1];
  logic [1:0]            st_op    [PIPE_STAGES+1];
  logic                  st_sign  [PIPE_STAGES+1];
  logic [TAG_W-1:0]      st_tag   [PIPE_STAGES+1];
  logic                  ready    [PIPE_STAGES+1];

  assign st_valid[0] = in_valid;
  assign st_data[0]  = A;
  assign st_b[0]     = B;
  assign st_op[0]    = Shiftop;
  assign st_sign[0]  = A[DATA_WIDTH-1];
  assign st_tag[0]   = in_tag;
  assign ready[PIPE_STAGES] = out_ready;

  for (genvar gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage
    localparam int FIRST = (gi * LPS < SHAMT_W) ? gi * LPS : SHAMT_W;
    localparam int NUM   = (SHAMT_W - FIRST < LPS) ? SHAMT_W - FIRST : LPS;

    // A stage may load when it is empty or its contents move on this cycle.
    assign ready[gi] = !st_valid[gi+1] || ready[gi+1];

    shifter_stage #(
      .DATA_WIDTH(DATA_WIDTH),
      .SHAMT_W   (SHAMT_W),
      .TAG_W     (TAG_W),
      .FIRST_LVL (FIRST),
      .NUM_LVL   (NUM)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .load     (ready[gi]),
      .in_valid (st_valid[gi]),
      .in_data  (st_data[gi]),
      .in_b     (st_b[gi]),
      .in_op    (st_op[gi]),
      .in_sign  (st_sign[gi]),
      .in_tag   (st_tag[gi]),
      .out_valid(st_valid[gi+1]),
      .out_data (st_data[gi+1]),
      .out_b    (st_b[gi+1]),
      .out_op   (st_op[gi+1]),
      .out_sign (st_sign[gi+1]),
      .out_tag  (st_tag[gi+1])
    );
  end

  assign in_ready  = ready[0];
  assign out_valid = st_valid[PIPE_STAGES];
  assign Result    = st_data[PIPE_STAGES];
  assign out_tag   = st_tag[PIPE_STAGES];

  // The final stage's control sideband has no consumer once all levels are applied.
  logic unused_tail;
  assign unused_tail = ^{st_b[PIPE_STAGES], st_op[PIPE_STAGES], st_sign[PIPE_STAGES]};

endmodule
